// File: rtl/pad_attr_cfg_ctrl.sv
// Pad attribute register owner: walks all pads to a default after reset, then
// serves sw/dbg write requests with round-robin arbitration. Values are
// masked to the attribute bits the pad type supports.
module pad_attr_cfg_ctrl #(
  parameter int unsigned NumPads = 8,
  parameter int unsigned AttrW = 4,
  // Derived from NumPads; leave at its default.
  parameter int unsigned IdxW = $clog2(NumPads),
  parameter logic [AttrW-1:0] DefaultAttr = '0,
  parameter logic [AttrW-1:0] SupportedMask = '1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     sw_req_i,
  input  logic [IdxW-1:0]          sw_idx_i,
  input  logic [AttrW-1:0]         sw_attr_i,
  output logic                     sw_gnt_o,
  input  logic                     dbg_req_i,
  input  logic [IdxW-1:0]          dbg_idx_i,
  input  logic [AttrW-1:0]         dbg_attr_i,
  output logic                     dbg_gnt_o,
  output logic [NumPads*AttrW-1:0] attr_o,
  output logic                     init_done_o,
  output logic                     busy_o,
  output logic                     upd_o,
  output logic [IdxW-1:0]          upd_idx_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StIdle  = 2'd1,
    StApply = 2'd2
  } state_e;

  localparam logic [IdxW:0]   NumPadsW = (IdxW+1)'(NumPads);
  localparam logic [IdxW-1:0] LastPad  = IdxW'(NumPads - 1);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    cnt_q, cnt_d;
  logic               rr_q, rr_d;          // 0: sw has priority, 1: dbg
  logic [IdxW-1:0]    lidx_q, lidx_d;
  logic [AttrW-1:0]   lattr_q, lattr_d;
  logic [AttrW-1:0]   attr_q [NumPads];
  logic [AttrW-1:0]   attr_d [NumPads];
  logic               sw_gnt_q, sw_gnt_d;
  logic               dbg_gnt_q, dbg_gnt_d;
  logic               upd_q, upd_d;
  logic [IdxW-1:0]    upd_idx_q, upd_idx_d;
  logic               err_q, err_d;
  logic               init_done_q, init_done_d;
  logic               busy_q, busy_d;
  logic               pick_dbg;
  logic [IdxW-1:0]    sel_idx;
  logic [AttrW-1:0]   sel_attr;

  // Next-state, arbitration and attribute update logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    lidx_d      = lidx_q;
    lattr_d     = lattr_q;
    attr_d      = attr_q;
    sw_gnt_d    = 1'b0;
    dbg_gnt_d   = 1'b0;
    upd_d       = 1'b0;
    upd_idx_d   = upd_idx_q;
    err_d       = 1'b0;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    pick_dbg    = dbg_req_i && (!sw_req_i || rr_q);
    sel_idx     = pick_dbg ? dbg_idx_i : sw_idx_i;
    sel_attr    = pick_dbg ? dbg_attr_i : sw_attr_i;

    unique case (state_q)
      StInit: begin
        attr_d[cnt_q] = DefaultAttr & SupportedMask;
        cnt_d         = cnt_q + IdxW'(1);
        busy_d        = 1'b1;
        if (cnt_q == LastPad) begin
          state_d     = StIdle;
          cnt_d       = '0;
          init_done_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      StIdle: begin
        busy_d = 1'b0;
        if (sw_req_i || dbg_req_i) begin
          lidx_d    = sel_idx;
          lattr_d   = sel_attr;
          rr_d      = !pick_dbg;
          sw_gnt_d  = !pick_dbg;
          dbg_gnt_d = pick_dbg;
          if ({1'b0, sel_idx} < NumPadsW) begin
            upd_d     = 1'b1;
            upd_idx_d = sel_idx;
          end else begin
            err_d = 1'b1;
          end
          busy_d  = 1'b1;
          state_d = StApply;
        end
      end
      StApply: begin
        if ({1'b0, lidx_q} < NumPadsW) begin
          attr_d[lidx_q] = lattr_q & SupportedMask;
        end
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      lidx_q      <= '0;
      lattr_q     <= '0;
      attr_q      <= '{default: '0};
      sw_gnt_q    <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      upd_q       <= 1'b0;
      upd_idx_q   <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      lidx_q      <= lidx_d;
      lattr_q     <= lattr_d;
      attr_q      <= attr_d;
      sw_gnt_q    <= sw_gnt_d;
      dbg_gnt_q   <= dbg_gnt_d;
      upd_q       <= upd_d;
      upd_idx_q   <= upd_idx_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  // Flatten the attribute array onto the output bus.
  for (genvar k = 0; k < NumPads; k++) begin : g_attr_out
    assign attr_o[k*AttrW +: AttrW] = attr_q[k];
  end

  assign sw_gnt_o    = sw_gnt_q;
  assign dbg_gnt_o   = dbg_gnt_q;
  assign upd_o       = upd_q;
  assign upd_idx_o   = upd_idx_q;
  assign err_o       = err_q;
  assign init_done_o = init_done_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_pad_attr_cfg_ctrl.sv
// Directed bench for pad_attr_cfg_ctrl: an 8-pad instance (default 5, mask 7)
// and a 10-pad instance (default A, full mask) for out-of-range indices.
module tb_pad_attr_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        sw_req = 1'b0, dbg_req = 1'b0;
  logic [2:0]  sw_idx = '0, dbg_idx = '0;
  logic [3:0]  sw_attr = '0, dbg_attr = '0;
  logic        sw_gnt, dbg_gnt, init_done, busy, upd, err;
  logic [2:0]  upd_idx;
  logic [31:0] attr;

  logic        sw10_req = 1'b0, dbg10_req = 1'b0;
  logic [3:0]  sw10_idx = '0, dbg10_idx = '0;
  logic [3:0]  sw10_attr = '0, dbg10_attr = '0;
  logic        sw10_gnt, dbg10_gnt, init_done10, busy10, upd10, err10;
  logic [3:0]  upd_idx10;
  logic [39:0] attr10;

  int n_tests = 0;
  int n_fail  = 0;

  pad_attr_cfg_ctrl #(
    .NumPads(8), .AttrW(4), .DefaultAttr(4'h5), .SupportedMask(4'h7)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .sw_req_i(sw_req), .sw_idx_i(sw_idx), .sw_attr_i(sw_attr), .sw_gnt_o(sw_gnt),
    .dbg_req_i(dbg_req), .dbg_idx_i(dbg_idx), .dbg_attr_i(dbg_attr), .dbg_gnt_o(dbg_gnt),
    .attr_o(attr), .init_done_o(init_done), .busy_o(busy),
    .upd_o(upd), .upd_idx_o(upd_idx), .err_o(err)
  );

  pad_attr_cfg_ctrl #(
    .NumPads(10), .AttrW(4), .DefaultAttr(4'hA), .SupportedMask(4'hF)
  ) u_dut10 (
    .clk_i(clk), .rst_ni(rst_n),
    .sw_req_i(sw10_req), .sw_idx_i(sw10_idx), .sw_attr_i(sw10_attr), .sw_gnt_o(sw10_gnt),
    .dbg_req_i(dbg10_req), .dbg_idx_i(dbg10_idx), .dbg_attr_i(dbg10_attr), .dbg_gnt_o(dbg10_gnt),
    .attr_o(attr10), .init_done_o(init_done10), .busy_o(busy10),
    .upd_o(upd10), .upd_idx_o(upd_idx10), .err_o(err10)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sr; logic [2:0] si; logic [3:0] sa;
    logic       dr; logic [2:0] di; logic [3:0] da;
    logic       e_sg; logic e_dg; logic e_up; logic [2:0] e_idx; logic e_busy;
    logic [31:0] e_attr;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Releases reset and checks the 8-pad init walk; dbg_req may be held by caller.
  task automatic init_walk(input logic [31:0] exp_attr);
    rst_n = 1'b1;
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_attr", 64'(attr), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("init_busy_c%0d", k), 64'(busy), 64'(k < 8));
      check($sformatf("init_done_c%0d", k), 64'(init_done), 64'(k == 8));
      check($sformatf("init_upd_c%0d", k), 64'(upd), 64'd0);
      check($sformatf("init_gnt_c%0d", k), 64'({sw_gnt, dbg_gnt}), 64'd0);
    end
    check("init_attr", 64'(attr), 64'(exp_attr));
  endtask

  initial begin
    //        sr si sa    dr di da    sg dg up idx busy attr
    vecs[0]  = '{1, 1, 2,    1, 2, 3,    1, 0, 1, 1, 1, 32'h55555555};
    vecs[1]  = '{0, 0, 0,    1, 2, 3,    0, 0, 0, 1, 0, 32'h55555525};
    vecs[2]  = '{0, 0, 0,    1, 2, 3,    0, 1, 1, 2, 1, 32'h55555525};
    vecs[3]  = '{0, 0, 0,    0, 0, 0,    0, 0, 0, 2, 0, 32'h55555325};
    vecs[4]  = '{1, 5, 4,    1, 6, 1,    1, 0, 1, 5, 1, 32'h55555325};
    vecs[5]  = '{0, 0, 0,    1, 6, 1,    0, 0, 0, 5, 0, 32'h55455325};
    vecs[6]  = '{0, 0, 0,    1, 6, 1,    0, 1, 1, 6, 1, 32'h55455325};
    vecs[7]  = '{0, 0, 0,    0, 0, 0,    0, 0, 0, 6, 0, 32'h51455325};
    vecs[8]  = '{1, 3, 4'hF, 0, 0, 0,    1, 0, 1, 3, 1, 32'h51455325};
    vecs[9]  = '{1, 0, 4'hE, 0, 0, 0,    0, 0, 0, 3, 0, 32'h51457325};
    vecs[10] = '{1, 0, 4'hE, 0, 0, 0,    1, 0, 1, 0, 1, 32'h51457325};
    vecs[11] = '{0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0, 32'h51457326};
    vecs[12] = '{1, 0, 1,    1, 0, 4'hF, 0, 1, 1, 0, 1, 32'h51457326};
    vecs[13] = '{1, 0, 1,    0, 0, 0,    0, 0, 0, 0, 0, 32'h51457327};
    vecs[14] = '{1, 0, 1,    0, 0, 0,    1, 0, 1, 0, 1, 32'h51457327};
    vecs[15] = '{0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0, 32'h51457321};
    vecs[16] = '{0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0, 32'h51457321};

    step();
    step();
    init_walk(32'h55555555);

    // Arbitration, masking, back-to-back and same-pad sequences.
    for (int i = 0; i < 17; i++) begin
      sw_req = vecs[i].sr; sw_idx = vecs[i].si; sw_attr = vecs[i].sa;
      dbg_req = vecs[i].dr; dbg_idx = vecs[i].di; dbg_attr = vecs[i].da;
      step();
      check($sformatf("v%0d_sw_gnt", i), 64'(sw_gnt), 64'(vecs[i].e_sg));
      check($sformatf("v%0d_dbg_gnt", i), 64'(dbg_gnt), 64'(vecs[i].e_dg));
      check($sformatf("v%0d_upd", i), 64'(upd), 64'(vecs[i].e_up));
      check($sformatf("v%0d_upd_idx", i), 64'(upd_idx), 64'(vecs[i].e_idx));
      check($sformatf("v%0d_err", i), 64'(err), 64'd0);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("v%0d_attr", i), 64'(attr), 64'(vecs[i].e_attr));
    end
    sw_req = 1'b0; dbg_req = 1'b0;

    // dbg request held through the init walk.
    rst_n = 1'b0;
    #1;
    dbg_req = 1'b1; dbg_idx = 3'd0; dbg_attr = 4'h6;
    step();
    init_walk(32'h55555555);
    step();
    check("hold_dbg_gnt", 64'(dbg_gnt), 64'd1);
    check("hold_upd", 64'({upd, upd_idx}), 64'({1'b1, 3'd0}));
    dbg_req = 1'b0;
    step();
    check("hold_attr", 64'(attr), 64'h55555556);
    check("hold_gnt_low", 64'(dbg_gnt), 64'd0);

    // Reset asserted in the APPLY cycle of a pad4 write.
    sw_req = 1'b1; sw_idx = 3'd4; sw_attr = 4'h3;
    step();
    check("rstapply_gnt", 64'({sw_gnt, upd, upd_idx}), 64'({1'b1, 1'b1, 3'd4}));
    rst_n = 1'b0;
    #1;
    check("rstapply_attr0", 64'(attr), 64'd0);
    check("rstapply_outs", 64'({sw_gnt, upd, upd_idx, init_done, busy}), 64'({1'b0, 1'b0, 3'd0, 1'b0, 1'b1}));
    sw_req = 1'b0;
    step();
    step();
    init_walk(32'h55555555);

    // 10-pad instance: out-of-range index raises err without a write.
    step(); step(); step();
    check("p10_init_done", 64'({init_done10, busy10, dbg10_gnt}), 64'({1'b1, 1'b0, 1'b0}));
    sw10_req = 1'b1; sw10_idx = 4'd10; sw10_attr = 4'h1;
    step();
    check("p10_idx10_gnt_err", 64'({sw10_gnt, err10, upd10}), 64'({1'b1, 1'b1, 1'b0}));
    sw10_req = 1'b0;
    step();
    check("p10_idx10_attr", 64'(attr10), 64'hAAAAAAAAAA);
    check("p10_err_pulse", 64'(err10), 64'd0);
    sw10_req = 1'b1; sw10_idx = 4'd15; sw10_attr = 4'h3;
    step();
    check("p10_idx15_gnt_err", 64'({sw10_gnt, err10, upd10}), 64'({1'b1, 1'b1, 1'b0}));
    sw10_req = 1'b0;
    step();
    check("p10_idx15_attr", 64'(attr10), 64'hAAAAAAAAAA);
    sw10_req = 1'b1; sw10_idx = 4'd9; sw10_attr = 4'h1;
    step();
    check("p10_idx9_upd", 64'({sw10_gnt, err10, upd10, upd_idx10}), 64'({1'b1, 1'b0, 1'b1, 4'd9}));
    sw10_req = 1'b0;
    step();
    check("p10_idx9_attr", 64'(attr10), 64'h1AAAAAAAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
